// File: rtl/arc4_ctrl.sv
// arc4_ctrl: sequences the init, ksa and prga engines over en/rdy handshakes,
// grants the single-port S memory to the active engine and watchdogs each phase.
`default_nettype none

module arc4_ctrl #(
  parameter int TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic       done,
  output logic       err,
  output logic [1:0] phase,
  output logic       init_en,
  output logic       ksa_en,
  output logic       prga_en,
  input  logic       init_rdy,
  input  logic       ksa_rdy,
  input  logic       prga_rdy,
  input  logic [7:0] init_addr,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] prga_addr,
  input  logic [7:0] init_wrdata,
  input  logic [7:0] ksa_wrdata,
  input  logic [7:0] prga_wrdata,
  input  logic       init_wren,
  input  logic       ksa_wren,
  input  logic       prga_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT_GO   = 3'd1,
    S_INIT_WAIT = 3'd2,
    S_KSA_GO    = 3'd3,
    S_KSA_WAIT  = 3'd4,
    S_PRGA_GO   = 3'd5,
    S_PRGA_WAIT = 3'd6,
    S_ERR       = 3'd7
  } state_t;

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] count;
  logic        expired;
  logic        go_entry;

  assign expired  = (count == LAST_COUNT);
  assign go_entry = (state_nxt != state) &&
                    (state_nxt == S_INIT_GO || state_nxt == S_KSA_GO || state_nxt == S_PRGA_GO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      count <= 16'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_PRGA_WAIT) && prga_rdy;
      if (go_entry)
        count <= 16'd0;
      else if (phase != 2'd0)
        count <= count + 16'd1;
    end
  end

  // Advancing (rdy seen) always takes priority over watchdog expiry.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    err       = 1'b0;
    phase     = 2'd0;
    init_en   = 1'b0;
    ksa_en    = 1'b0;
    prga_en   = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    case (state)
      S_IDLE: begin
        rdy = 1'b1;
        if (en) state_nxt = S_INIT_GO;
      end
      S_INIT_GO, S_INIT_WAIT: begin
        phase    = 2'd1;
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
        init_en  = (state == S_INIT_GO) && init_rdy;
        if (init_rdy)
          state_nxt = (state == S_INIT_GO) ? S_INIT_WAIT : S_KSA_GO;
        else if (expired)
          state_nxt = S_ERR;
      end
      S_KSA_GO, S_KSA_WAIT: begin
        phase    = 2'd2;
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
        ksa_en   = (state == S_KSA_GO) && ksa_rdy;
        if (ksa_rdy)
          state_nxt = (state == S_KSA_GO) ? S_KSA_WAIT : S_PRGA_GO;
        else if (expired)
          state_nxt = S_ERR;
      end
      S_PRGA_GO, S_PRGA_WAIT: begin
        phase    = 2'd3;
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
        prga_en  = (state == S_PRGA_GO) && prga_rdy;
        if (prga_rdy)
          state_nxt = (state == S_PRGA_GO) ? S_PRGA_WAIT : S_IDLE;
        else if (expired)
          state_nxt = S_ERR;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire
